// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory port plus the decode handshake
// and the branch-redirect inputs from execute.
//   master (fetch_unit): drives i_addr, instr, instr_pc, instr_valid
//   slave  (environment): drives i_bus, redirect, redirect_pc, instr_ready
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_bus;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready;

  modport master (
    output i_addr, instr, instr_pc, instr_valid,
    input  i_bus, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  i_addr, instr, instr_pc, instr_valid,
    output i_bus, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one word address per cycle to a
// fixed 1-cycle-latency memory, tags returned words with their PC and queues
// them in a 2-entry buffer feeding decode over valid/ready. A redirect flushes
// the stage and issues the new target in the same cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus.i_addr        fetch address (combinational: redirect_pc on redirect)
//   bus.i_bus         memory data for the address sampled at the previous edge
//   bus.redirect(_pc) flush and refetch from redirect_pc
//   bus.instr/_pc     buffer head word and its address
//   bus.instr_valid   head valid (masked during redirect)
//   bus.instr_ready   decode accepts the head
module fetch_unit #(
  parameter int unsigned         WIDTH    = 16,
  parameter logic [WIDTH-1:0]    RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  entry_t           fifo_q [2];
  entry_t           fifo_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;

  logic [WIDTH-1:0] fetch_addr_c;
  logic             valid_c;
  logic             pop_c;
  logic             push_c;
  logic             issue_c;
  logic [2:0]       occupancy_c;

  // Handshake and issue decisions
  always_comb begin
    fetch_addr_c = bus.redirect ? bus.redirect_pc : pc_q;
    valid_c      = (count_q != 2'd0) & ~bus.redirect;
    pop_c        = valid_c & bus.instr_ready;
    push_c       = inflight_q & ~bus.redirect;
    // Slots that will be spoken for after this edge; issue only if one is free
    occupancy_c  = 3'(count_q) + 3'(inflight_q) - 3'(pop_c);
    issue_c      = bus.redirect | (occupancy_c < 3'd2);
  end

  // Next-state logic
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue_c;
    inflight_pc_d = inflight_pc_q;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (issue_c) begin
      pc_d          = fetch_addr_c + WIDTH'(1);
      inflight_pc_d = fetch_addr_c;
    end

    if (push_c) begin
      fifo_d[wr_ptr_q] = '{instr: bus.i_bus, pc: inflight_pc_q};
    end

    if (bus.redirect) begin
      // Flush: buffered words and the word on i_bus are both stale
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      rd_ptr_d = rd_ptr_q ^ pop_c;
      wr_ptr_d = wr_ptr_q ^ push_c;
      count_d  = count_q + 2'(push_c) - 2'(pop_c);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // The issue rule keeps the buffer from ever exceeding two entries
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= 2'd2);
    end
  end

  // Outputs
  always_comb begin
    bus.i_addr      = fetch_addr_c;
    bus.instr       = fifo_q[rd_ptr_q].instr;
    bus.instr_pc    = fifo_q[rd_ptr_q].pc;
    bus.instr_valid = valid_c;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model answering one cycle after each
// address, and a scoreboard of expected {instr, pc} pairs pushed when a stream
// is started and popped as decode accepts each word.
module tb_fetch_unit;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic [W-1:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q[$];

  fetch_unit_if #(.WIDTH(W)) bus ();

  fetch_unit #(.WIDTH(W), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: odd multiplier makes every address hold a distinct word
  function automatic logic [W-1:0] mem_f(input logic [W-1:0] a);
    logic [W-1:0] t;
    t = a * 16'd7;
    return t ^ 16'hC35A;
  endfunction

  always_ff @(posedge clk) bus.i_bus <= mem_f(bus.i_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] pc);
    q.push_back('{d: mem_f(pc), pc: pc});
  endtask

  // Compare the presented head against the scoreboard; pop on transfer
  task automatic mon();
    if (bus.instr_valid === 1'b1) begin
      chk("mon_expected_present", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        chk("mon_instr", 32'(bus.instr), 32'(q[0].d));
        chk("mon_pc", 32'(bus.instr_pc), 32'(q[0].pc));
        if (bus.instr_ready === 1'b1) void'(q.pop_front());
      end
    end
  endtask

  task automatic edge_t();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.instr_ready = rdy;
    q.delete();
    edge_t();
    edge_t();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;

    // Reset state
    edge_t();
    edge_t();
    @(negedge clk);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst_i_addr", 32'(bus.i_addr), 32'h0000);

    // Reset release, streaming at full rate
    for (int i = 0; i < 4; i++) push_exp(W'(i));
    rst = 1'b0;
    edge_t(); sample();
    chk("lat_edge1_valid", 32'(bus.instr_valid), 32'd0);
    edge_t(); sample();
    chk("lat_edge2_valid", 32'(bus.instr_valid), 32'd1);
    repeat (3) begin edge_t(); sample(); end
    chk("stream_drain", 32'(q.size()), 32'd0);

    // Back-pressure from the first valid
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) push_exp(W'(i));
    edge_t(); sample();
    chk("bp_edge1_valid", 32'(bus.instr_valid), 32'd0);
    edge_t(); sample();
    chk("bp_first_valid", 32'(bus.instr_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      edge_t(); sample();
      chk("bp_i_addr_stall", 32'(bus.i_addr), 32'd2);
      chk("bp_hold_valid", 32'(bus.instr_valid), 32'd1);
    end
    edge_t();
    bus.instr_ready = 1'b1;
    sample();
    chk("bp_release_i_addr", 32'(bus.i_addr), 32'd2);
    edge_t(); sample();
    edge_t(); sample();
    chk("bp_no_gap_q", 32'(q.size()), 32'd2);

    // Fill the buffer again, then redirect to 0x0040
    edge_t();
    bus.instr_ready = 1'b0;
    sample();
    edge_t(); sample();
    chk("full_i_addr", 32'(bus.i_addr), 32'd5);
    edge_t();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    q.delete();
    push_exp(16'h0040);
    push_exp(16'h0041);
    sample();
    chk("redir_mask_valid", 32'(bus.instr_valid), 32'd0);
    chk("redir_i_addr", 32'(bus.i_addr), 32'h0040);
    edge_t();
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    sample();
    chk("redir_gap_valid", 32'(bus.instr_valid), 32'd0);
    edge_t(); sample();
    chk("redir_first_valid", 32'(bus.instr_valid), 32'd1);
    edge_t(); sample();
    chk("redir_drain", 32'(q.size()), 32'd0);

    // Address wrap-around
    edge_t();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    q.delete();
    push_exp(16'hFFFE);
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    push_exp(16'h0001);
    sample();
    chk("wrap_mask_valid", 32'(bus.instr_valid), 32'd0);
    edge_t();
    bus.redirect = 1'b0;
    sample();
    chk("wrap_gap_valid", 32'(bus.instr_valid), 32'd0);
    repeat (4) begin edge_t(); sample(); end
    chk("wrap_drain", 32'(q.size()), 32'd0);

    // Back-to-back redirects: only the second target survives
    edge_t();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0010;
    q.delete();
    push_exp(16'h0020);
    push_exp(16'h0021);
    sample();
    chk("b2b_mask1_valid", 32'(bus.instr_valid), 32'd0);
    edge_t();
    bus.redirect_pc = 16'h0020;
    sample();
    chk("b2b_mask2_valid", 32'(bus.instr_valid), 32'd0);
    edge_t();
    bus.redirect = 1'b0;
    sample();
    chk("b2b_gap_valid", 32'(bus.instr_valid), 32'd0);
    edge_t(); sample();
    chk("b2b_first_valid", 32'(bus.instr_valid), 32'd1);
    edge_t(); sample();
    chk("b2b_drain", 32'(q.size()), 32'd0);

    // Asynchronous reset between edges mid-stream
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_i_addr", 32'(bus.i_addr), 32'h0000);
    chk("arst_instr_pc", 32'(bus.instr_pc), 32'd0);
    q.delete();
    for (int i = 0; i < 3; i++) push_exp(W'(i));
    edge_t();
    edge_t();
    @(negedge clk);
    rst = 1'b0;
    edge_t(); sample();
    chk("arst_edge1_valid", 32'(bus.instr_valid), 32'd0);
    edge_t(); sample();
    chk("arst_edge2_valid", 32'(bus.instr_valid), 32'd1);
    edge_t(); sample();
    edge_t(); sample();
    chk("arst_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
